pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Merges decode load-use requests, multiply/divide occupancy and MEM-stage exception flushes.
- Produces per-register enable/clear strobes.
- Owns the multi-cycle mult/div busy counter and the HI/LO write strobe.
- Keeps a stall-cycle performance counter.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu
CNT_W, 4, width of the busy counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)
PERF_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ld_use_req  in  1  decode load-use hazard (combinational from ID)
md_use_D  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
md_start  in  1  mult/div instruction in EX issues this cycle
md_is_div  in  1  qualifies md_start: 1 = div/divu, 0 = mult/multu
flush_req  in  1  exception/eret resolved in MEM; kill younger stages
en_F  out  1  PC register enable
en_D  out  1  IF/ID enable
clr_D  out  1  IF/ID synchronous clear
clr_E  out  1  ID/EX clear (bubble insert)
clr_M  out  1  EX/MEM clear
md_busy  out  1  mult/div unit occupied
hilo_we  out  1  HI/LO write strobe, single cycle
stall_cycles  out  PERF_W  count of stalled cycles, wraps

Behaviour:
States (registered): IDLE, BUSY. Registered values are the state, cnt[CNT_W-1:0], is_div and stall_cycles.

Reset (rst=0, async):
- state=IDLE, cnt=0, stall_cycles=0.
- While rst=0, outputs are forced to en_F=0, en_D=0, clr_D=1, clr_E=1, clr_M=1, md_busy=0, hilo_we=0.

Issue qualification:
- md_go = md_start & ~flush_req & (state==IDLE).
- md_start while BUSY is ignored: no reload, no effect on cnt.

IDLE:
- md_go loads cnt = md_is_div ? DIV_CYCLES : MULT_CYCLES, latches is_div and moves to BUSY.
- After an issue at edge k, md_busy=1 for exactly N cycles (k+1 .. k+N).

BUSY:
- cnt decrements once per cycle.
- hilo_we=1 in the cycle where cnt==1.
- On the next edge, state goes to IDLE with cnt=0; md_busy=0 from that cycle.
- flush_req does not abort BUSY. The issued op has already passed EX and completes.

Stall logic (combinational):
- stall_md = md_use_D & (md_busy | md_start).
- stall = (ld_use_req | stall_md) & ~flush_req.
- stall=1 gives en_F=0, en_D=0, clr_E=1. EX/MEM keeps advancing (clr_M=0).

Flush (highest priority, combinational):
- flush_req=1 gives en_F=1 (PC loads handler), en_D=1, clr_D=1, clr_E=1, clr_M=1.
- Stall requests are overridden in a flush cycle.

Default (no stall, no flush): en_F=en_D=1, all clears 0.

stall_cycles:
- Increments on each edge where stall=1.
- Wraps modulo 2^PERF_W.
- Not incremented in flush cycles.

Simultaneous events:
- ld_use_req and stall_md together count as one stall cycle.
- md_start with md_use_D in the same cycle stalls ID even while IDLE.

Decomposition:
- Shared package cpu_pkg holds: state encoding (S_IDLE=1'b0, S_BUSY=1'b1), MULT_CYCLES/DIV_CYCLES defaults, CNT_W.
- One natural sub-module, md_busy_timer: cnt/state/is_div registers, hilo_we, md_busy.
- The top level holds the combinational stall/flush priority network and stall_cycles.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with random inputs, then release -> en_F=0, clr_D/E/M=1 while low; after release md_busy=0, stall_cycles=0, en_F=en_D=1.
2. Mult timing: md_start=1, md_is_div=0 at cycle 10 -> md_busy=1 in cycles 11..15, hilo_we=1 only in cycle 15, md_busy=0 in cycle 16.
3. Div plus mflo dependency: md_start=1, md_is_div=1 at cycle 0, md_use_D=1 from cycle 0 -> en_D=0 and clr_E=1 in cycles 0..10, en_D=1 in cycle 11, stall_cycles=11.
4. Load-use: ld_use_req=1 for 1 cycle while IDLE -> en_F=en_D=0, clr_E=1, clr_M=0 for that cycle; stall_cycles increments by 1.
5. Flush priority: flush_req=1 together with md_start=1 and ld_use_req=1 -> no issue (md_busy stays 0), en_F=1, clr_D=clr_E=clr_M=1, stall_cycles unchanged.
6. Flush during BUSY plus reset mid-op: flush_req at cnt=3 -> busy continues, hilo_we still fires; separate run with rst=0 at cnt=4 -> md_busy=0 immediately, no hilo_we, and the counter does not resume after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: mult/div sequencer state encoding and latency defaults.
package cpu_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: counts down the unit latency and strobes the HI/LO write on the last cycle.
module md_busy_timer
   import cpu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic md_go,
   input  logic md_is_div,
   output logic md_busy,
   output logic hilo_we
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               is_div, is_div_nxt;

   // is_div is kept for debug visibility of the in-flight op type
   logic unused_is_div;
   assign unused_is_div = is_div;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         is_div <= is_div_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      is_div_nxt = is_div;
      md_busy    = 1'b0;
      hilo_we    = 1'b0;
      case (state)
         S_IDLE: begin
            if (md_go) begin
               cnt_nxt    = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               is_div_nxt = md_is_div;
               state_nxt  = S_BUSY;
            end
         end
         S_BUSY: begin
            md_busy = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
            // last busy cycle: result lands in HI/LO
            if (cnt == CNT_W'(1)) begin
               hilo_we   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use, mult/div occupancy and exception flush into register strobes.
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_use_req,
   input  logic              md_use_D,
   input  logic              md_start,
   input  logic              md_is_div,
   input  logic              flush_req,
   output logic              en_F,
   output logic              en_D,
   output logic              clr_D,
   output logic              clr_E,
   output logic              clr_M,
   output logic              md_busy,
   output logic              hilo_we,
   output logic [PERF_W-1:0] stall_cycles
);

   logic md_go;
   logic stall_md;
   logic stall;

   // md_busy is low exactly when the timer is idle, so it doubles as the issue qualifier
   assign md_go    = md_start & ~flush_req & ~md_busy;
   assign stall_md = md_use_D & (md_busy | md_start);
   assign stall    = (ld_use_req | stall_md) & ~flush_req;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_timer (
      .clk       (clk),
      .rst       (rst),
      .md_go     (md_go),
      .md_is_div (md_is_div),
      .md_busy   (md_busy),
      .hilo_we   (hilo_we)
   );

   // Priority: reset, then flush, then stall
   always_comb begin
      en_F  = 1'b1;
      en_D  = 1'b1;
      clr_D = 1'b0;
      clr_E = 1'b0;
      clr_M = 1'b0;
      if (!rst) begin
         en_F  = 1'b0;
         en_D  = 1'b0;
         clr_D = 1'b1;
         clr_E = 1'b1;
         clr_M = 1'b1;
      end else if (flush_req) begin
         clr_D = 1'b1;
         clr_E = 1'b1;
         clr_M = 1'b1;
      end else if (stall) begin
         en_F  = 1'b0;
         en_D  = 1'b0;
         clr_E = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (stall) begin
         stall_cycles <= stall_cycles + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors, directed corner sequences and a reference model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_use_req, md_use_D, md_start, md_is_div, flush_req;
   logic        en_F, en_D, clr_D, clr_E, clr_M, md_busy, hilo_we;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ld_use_req   (ld_use_req),
      .md_use_D     (md_use_D),
      .md_start     (md_start),
      .md_is_div    (md_is_div),
      .flush_req    (flush_req),
      .en_F         (en_F),
      .en_D         (en_D),
      .clr_D        (clr_D),
      .clr_E        (clr_E),
      .clr_M        (clr_M),
      .md_busy      (md_busy),
      .hilo_we      (hilo_we),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  ctl;   // {en_F,en_D,clr_D,clr_E,clr_M,md_busy,hilo_we}
      logic [31:0] sc;
   } exp_t;

   typedef struct {
      logic       ld, ud, st, dv, fl;
      logic [4:0] exp_ctl; // {en_F,en_D,clr_D,clr_E,clr_M}
   } vec_t;

   exp_t sb[$];

   // Reference model: remaining busy cycles and stall count
   int          m_rem   = 0;
   logic [31:0] m_stall = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic ld, input logic ud, input logic st,
                       input logic dv, input logic fl);
      exp_t e;
      exp_t g;
      logic busy_m, hilo_m, stall_m;
      @(posedge clk);
      #1;
      rst = r; ld_use_req = ld; md_use_D = ud; md_start = st; md_is_div = dv; flush_req = fl;
      #3;
      stall_m = 1'b0;
      if (!r) begin
         m_rem   = 0;
         m_stall = '0;
         e.ctl   = 7'b00_111_00;
         e.sc    = '0;
      end else begin
         busy_m  = (m_rem > 0);
         hilo_m  = (m_rem == 1);
         stall_m = (ld | (ud & (busy_m | st))) & ~fl;
         if (fl)           e.ctl = {5'b11111, busy_m, hilo_m};
         else if (stall_m) e.ctl = {5'b00010, busy_m, hilo_m};
         else              e.ctl = {5'b11000, busy_m, hilo_m};
         e.sc = m_stall;
      end
      sb.push_back(e);
      g = sb.pop_front();
      check("ctl", 32'({en_F, en_D, clr_D, clr_E, clr_M, md_busy, hilo_we}), 32'(g.ctl));
      check("stall_cycles", stall_cycles, g.sc);
      if (r) begin
         if (m_rem > 0)      m_rem--;
         else if (st && !fl) m_rem = dv ? 10 : 5;
         if (stall_m)        m_stall++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
   endtask

   vec_t        vecs[8];
   logic [31:0] base;
   int          hilo_seen;

   initial begin
      vecs[0] = '{0,0,0,0,0, 5'b11000};
      vecs[1] = '{1,0,0,0,0, 5'b00010};
      vecs[2] = '{0,1,0,0,0, 5'b11000};
      vecs[3] = '{1,1,0,0,0, 5'b00010};
      vecs[4] = '{1,0,0,0,1, 5'b11111};
      vecs[5] = '{1,1,1,0,1, 5'b11111};
      vecs[6] = '{0,0,1,1,1, 5'b11111};
      vecs[7] = '{0,1,1,0,1, 5'b11111};

      rst = 1'b0; ld_use_req = 0; md_use_D = 0; md_start = 0; md_is_div = 0; flush_req = 0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("rst_en_F", 32'(en_F), 0);
         check("rst_clr_M", 32'(clr_M), 1);
      end
      step(1, 0, 0, 0, 0, 0);
      check("post_rst_busy", 32'(md_busy), 0);
      check("post_rst_sc", stall_cycles, 0);
      check("post_rst_en_D", 32'(en_D), 1);

      // Combinational priority table, unit stays idle
      for (int i = 0; i < 8; i++) begin
         step(1, vecs[i].ld, vecs[i].ud, vecs[i].st, vecs[i].dv, vecs[i].fl);
         check($sformatf("vec%0d", i), 32'({en_F, en_D, clr_D, clr_E, clr_M}), 32'(vecs[i].exp_ctl));
      end
      step(1, 0, 0, 0, 0, 0);
      check("vec_no_issue", 32'(md_busy), 0);

      // Load-use single stall
      base = stall_cycles;
      step(1, 1, 0, 0, 0, 0);
      check("lu_clr_M", 32'(clr_M), 0);
      step(1, 0, 0, 0, 0, 0);
      check("lu_sc_delta", stall_cycles - base, 1);

      // Flush beats issue and stall
      base = stall_cycles;
      step(1, 1, 1, 1, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      check("fl_no_issue", 32'(md_busy), 0);
      check("fl_sc_same", stall_cycles, base);

      // Mult timing
      step(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0, 0);
         check($sformatf("mul_busy%0d", i), 32'(md_busy), 1);
         check($sformatf("mul_hilo%0d", i), 32'(hilo_we), (i == 4) ? 1 : 0);
      end
      step(1, 0, 0, 0, 0, 0);
      check("mul_done", 32'(md_busy), 0);

      // Div with dependent mflo in decode
      base = stall_cycles;
      step(1, 0, 1, 1, 1, 0);
      check("div_en_D0", 32'(en_D), 0);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, 0);
      check("div_en_D10", 32'(en_D), 0);
      step(1, 0, 1, 0, 0, 0);
      check("div_en_D11", 32'(en_D), 1);
      check("div_sc_delta", stall_cycles - base, 11);
      idle(2);

      // Flush during busy does not abort the op
      hilo_seen = 0;
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      check("fl_busy_kept", 32'(md_busy), 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0);
         if (hilo_we) hilo_seen++;
      end
      check("fl_hilo_once", 32'(hilo_seen), 1);

      // Reset mid-div kills the op for good
      step(1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
      check("div_busy_pre", 32'(md_busy), 1);
      step(0, 0, 0, 0, 0, 0);
      check("rst_mid_busy", 32'(md_busy), 0);
      check("rst_mid_hilo", 32'(hilo_we), 0);
      hilo_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 0, 0, 0, 0);
         if (md_busy || hilo_we) hilo_seen++;
      end
      check("rst_no_resume", 32'(hilo_seen), 0);

      // Random traffic against the model
      for (int i = 0; i < 300; i++)
         step(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
